// File: rtl/fp32_p8.sv
// IEEE-754 binary32 to posit<8,0> converter, two-stage valid/ready pipeline.
// S1 registers the decoded fields and S2 registers the rounded posit8 with its flags.
module fp32_p8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] fp32,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  p8,
  output logic        inexact,
  output logic        sat
);

  localparam logic [1:0] C_ZERO    = 2'd0;
  localparam logic [1:0] C_DENORM  = 2'd1;
  localparam logic [1:0] C_SPECIAL = 2'd2;
  localparam logic [1:0] C_NORMAL  = 2'd3;

  logic              s1_v, s2_v, s2_ld;
  logic              s1_sign;
  logic signed [8:0] s1_k;
  logic [22:0]       s1_m;
  logic [1:0]        s1_cls;

  logic [1:0]        d_cls;
  logic signed [8:0] d_k;

  // Stage n loads when it is empty or its successor drains this cycle.
  assign s2_ld     = !s2_v || out_ready;
  assign in_ready  = !rst && (!s1_v || s2_ld);
  assign out_valid = s2_v;

  // ---------------- decode ----------------
  assign d_k = $signed({1'b0, fp32[30:23]}) - 9'sd127;

  always_comb begin
    d_cls = C_NORMAL;
    if (fp32[30:23] == 8'h00)
      d_cls = (fp32[22:0] == 23'd0) ? C_ZERO : C_DENORM;
    else if (fp32[30:23] == 8'hFF)
      d_cls = C_SPECIAL;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_sign <= 1'b0;
      s1_k    <= '0;
      s1_m    <= '0;
      s1_cls  <= C_ZERO;
    end else if (in_ready) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_sign <= fp32[31];
        s1_k    <= d_k;
        s1_m    <= fp32[22:0];
        s1_cls  <= d_cls;
      end
    end
  end

  // ---------------- encode / round ----------------
  logic [2:0]  kk, nk, rl, sh;
  logic [6:0]  reg7, body;
  logic [29:0] wide;
  logic        guard, sticky;
  logic [7:0]  rnd;
  logic [7:0]  e_p8;
  logic        e_ix, e_sat, e_signed;

  // The regime is left-aligned in a 30-bit stream and the mantissa follows it;
  // the top 7 bits form the body, then guard, then sticky.
  always_comb begin
    kk   = s1_k[2:0];
    nk   = 3'd0 - kk;
    reg7 = '0;
    rl   = 3'd7;
    if (!s1_k[8]) begin
      if (kk == 3'd6) begin
        reg7 = 7'h7F;
        rl   = 3'd7;
      end else begin
        reg7 = ~(7'h7F >> (kk + 3'd1));
        rl   = kk + 3'd2;
      end
    end else begin
      reg7 = 7'h40 >> nk;
      rl   = nk + 3'd1;
    end
    sh     = 3'd7 - rl;
    wide   = {reg7, 23'd0} | ({7'd0, s1_m} << sh);
    guard  = wide[22];
    sticky = |wide[21:0];
    rnd    = {1'b0, wide[29:23]} + {7'd0, guard & (sticky | wide[23])};
  end

  always_comb begin
    body     = '0;
    e_ix     = 1'b0;
    e_sat    = 1'b0;
    e_signed = 1'b1;
    e_p8     = '0;
    case (s1_cls)
      C_ZERO: begin
        e_signed = 1'b0;
      end
      C_SPECIAL: begin
        e_signed = 1'b0;
        e_ix     = 1'b1;
      end
      C_DENORM: begin
        body  = 7'h01;
        e_ix  = 1'b1;
        e_sat = 1'b1;
      end
      default: begin
        if (s1_k < -9'sd6) begin
          body  = 7'h01;
          e_ix  = 1'b1;
          e_sat = 1'b1;
        end else if (s1_k > 9'sd6 || (s1_k == 9'sd6 && s1_m != 23'd0)) begin
          body  = 7'h7F;
          e_ix  = 1'b1;
          e_sat = 1'b1;
        end else if (rnd[7]) begin
          body  = 7'h7F;
          e_ix  = 1'b1;
          e_sat = 1'b1;
        end else begin
          body = rnd[6:0];
          e_ix = guard | sticky;
        end
      end
    endcase
    if (s1_cls == C_SPECIAL)
      e_p8 = 8'h80;
    else if (e_signed && s1_sign)
      e_p8 = ~{1'b0, body} + 8'd1;
    else
      e_p8 = {1'b0, body};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v    <= 1'b0;
      p8      <= 8'h00;
      inexact <= 1'b0;
      sat     <= 1'b0;
    end else if (s2_ld) begin
      s2_v <= s1_v;
      if (s1_v) begin
        p8      <= e_p8;
        inexact <= e_ix;
        sat     <= e_sat;
      end
    end
  end

endmodule

// File: tb/tb_fp32_p8.sv
// Bench for fp32_p8: vector table through a scoreboard queue, plus
// reset, latency, backpressure and mid-stream reset sequences.
module tb_fp32_p8;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] fp32 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  p8;
  logic        inexact;
  logic        sat;

  typedef struct {
    logic [31:0] w;
    logic [7:0]  p;
    logic        ix;
    logic        st;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];
  vec_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_out = 0;

  fp32_p8 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .fp32(fp32),
    .out_valid(out_valid), .out_ready(out_ready), .p8(p8), .inexact(inexact), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard: every valid output cycle is compared to the oldest outstanding entry.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL spurious_out: got p8=%h with nothing expected", p8);
      end else begin
        chk($sformatf("result_%h", sb[0].w), 32'({p8, inexact, sat}),
            32'({sb[0].p, sb[0].ix, sb[0].st}));
        if (out_ready) begin
          void'(sb.pop_front());
          n_out++;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input vec_t v);
    int t;
    in_valid = 1'b1;
    fp32     = v.w;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_chk++;
      $display("FAIL send_timeout: in_ready stuck at %b, required 1", in_ready);
    end else begin
      sb.push_back(v);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int base;
    vecs[0]  = '{32'h3F800000, 8'h40, 1'b0, 1'b0};
    vecs[1]  = '{32'h3FC00000, 8'h50, 1'b0, 1'b0};
    vecs[2]  = '{32'hBF800000, 8'hC0, 1'b0, 1'b0};
    vecs[3]  = '{32'h42800000, 8'h7F, 1'b0, 1'b0};
    vecs[4]  = '{32'h3C800000, 8'h01, 1'b0, 1'b0};
    vecs[5]  = '{32'h80000000, 8'h00, 1'b0, 1'b0};
    vecs[6]  = '{32'h3F820000, 8'h40, 1'b1, 1'b0};
    vecs[7]  = '{32'h3F860000, 8'h42, 1'b1, 1'b0};
    vecs[8]  = '{32'h42400000, 8'h7E, 1'b1, 1'b0};
    vecs[9]  = '{32'h42600000, 8'h7F, 1'b1, 1'b0};
    vecs[10] = '{32'h42C80000, 8'h7F, 1'b1, 1'b1};
    vecs[11] = '{32'h3B800000, 8'h01, 1'b1, 1'b1};
    vecs[12] = '{32'h00000001, 8'h01, 1'b1, 1'b1};
    vecs[13] = '{32'hC2C80000, 8'h81, 1'b1, 1'b1};
    vecs[14] = '{32'h7FC00000, 8'h80, 1'b1, 1'b0};
    vecs[15] = '{32'h7F800000, 8'h80, 1'b1, 1'b0};
    vecs[16] = '{32'h00000000, 8'h00, 1'b0, 1'b0};
    vecs[17] = '{32'hBFC00000, 8'hB0, 1'b0, 1'b0};
    vecs[18] = '{32'h3CC00000, 8'h02, 1'b1, 1'b0};
    vecs[19] = '{32'h41800000, 8'h7C, 1'b0, 1'b0};
    vecs[20] = '{32'hC2800000, 8'h81, 1'b0, 1'b0};

    // Reset held with in_valid high: nothing may come out.
    in_valid = 1'b1;
    fp32     = 32'h3F800000;
    repeat (3) begin
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
    end
    chk("rst_p8", 32'(p8), 32'h00);
    chk("rst_flags", 32'({inexact, sat}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Latency: presented cycle, then S1, then out_valid.
    send(vecs[0]);
    @(negedge clk);
    chk("lat_s1_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_s2_out_valid", 32'(out_valid), 32'd1);
    drain();

    // Vector table, back-to-back with out_ready high.
    @(posedge clk);
    #1;
    for (int i = 0; i < NV; i++) send(vecs[i]);
    drain();

    // Backpressure: 6 words while out_ready is low for 4 cycles.
    base = n_out;
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 6; i < 12; i++) send(vecs[i]);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        chk("bp_out_valid_held", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", 32'(n_out - base), 32'd6);

    // Async reset with two words in flight.
    @(posedge clk);
    #1;
    send(vecs[1]);
    send(vecs[2]);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_p8", 32'(p8), 32'h00);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("post_rst_no_stale", 32'(out_valid), 32'd0);
    end

    // Pipeline still works after the reset.
    @(posedge clk);
    #1;
    send(vecs[13]);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/fp32_p8.md
Name: fp32_p8

Overview:
- Pipelined IEEE-754 binary32 to posit<8,0> converter; the inverse of the posit8-to-fp32 decoder in the posit processing unit.
- Accepts one fp32 word per cycle through a valid/ready handshake.
- Produces the nearest posit8 (round-to-nearest-even) plus inexact and saturation flags.
- Sits on the PPU store/writeback path, where fp32 results are packed back into posit8 registers.

Parameters:
- none. Format is fixed: posit8, es=0, maxpos=0x7F (64.0), minpos=0x01 (2^-6).

Ports:
- clk        input   1   system clock, rising edge
- rst        input   1   reset, asynchronous, active-high
- in_valid   input   1   fp32 input valid
- in_ready   output  1   converter can accept input this cycle
- fp32       input   32  IEEE-754 binary32 operand
- out_valid  output  1   result valid
- out_ready  input   1   downstream accepts result
- p8         output  8   posit8 result, two's complement
- inexact    output  1   result differs from the exact input value
- sat        output  1   magnitude clamped to maxpos or minpos

Behaviour:
- Reset, asynchronous, active-high: out_valid=0, p8=0x00, inexact=0, sat=0, all stage valids=0. in_ready goes to 1 the first cycle after rst deasserts. Reset mid-operation discards all in-flight data; no output is produced for it.
- Handshake: a transfer occurs when valid&ready are both high on a clk edge. Outputs hold stable while out_valid=1 and out_ready=0.
- Pipeline: 2 registered stages (S1 decode, S2 encode/round). Latency is exactly 2 cycles from input accept to out_valid. Throughput is 1 word per cycle.
- Stall rules:
  - Stage n loads when it is empty or stage n+1 loads / output is consumed this cycle.
  - in_ready = !S1_valid | S1_advances. in_ready is combinational from out_ready; no bubbles are inserted.
- S1 decode:
  - Register sign, unbiased exponent k=e-127 as 9-bit signed, mantissa m[22:0].
  - Register class: ZERO (e=0, including denormals with m=0), DENORM (e=0, m!=0), SPECIAL (e=255), NORMAL.
- S2 encode:
  - ZERO -> 0x00, inexact=0, sat=0. Both +0 and -0 give 0x00.
  - SPECIAL (Inf or NaN) -> NaR 0x80, inexact=1, sat=0.
  - DENORM, or NORMAL with k<-6 -> body 0x01 (minpos), sat=1, inexact=1. A posit never rounds to zero.
  - NORMAL with k>6, or k=6 with m!=0 -> body 0x7F, sat=1, inexact=1.
  - NORMAL with -6<=k<=6, regime field:
    - k>=0: k+1 ones then a 0 (length k+2); for k=6, 7 ones with no terminator.
    - k<0: -k zeros then a 1 (length 1-k).
  - Fraction bits = 7 - regime length, taken from the MSBs of m.
  - Guard = next bit of m; sticky = OR of the remaining bits.
  - Rounding is RNE on the 7-bit body: increment when guard & (sticky | lsb). Carry may ripple into the regime, which is legal because the encoding is monotonic. A body result of 0x80 clamps to 0x7F with sat=1.
  - inexact = guard | sticky (or set by any clamp).
  - Sign: p8 = sign ? (~{0,body}+1) : {0,body}. NaR and zero are not negated.
- Simultaneous accept and emit in the same cycle are fully supported. Back-to-back inputs under a continuous out_ready=0 fill 2 entries, then in_ready=0.

Test Plan:
- Reset with in_valid=1 held -> out_valid=0 throughout. After release, fp32=0x3F800000 (1.0) -> p8=0x40 exactly 2 cycles later, inexact=0, sat=0.
- Exact and signed values:
  - 0x3FC00000 (1.5) -> 0x50
  - 0xBF800000 (-1.0) -> 0xC0
  - 0x42800000 (64.0) -> 0x7F, sat=0
  - 0x3C800000 (2^-6) -> 0x01, sat=0
  - 0x80000000 -> 0x00
- Rounding:
  - 0x3F820000 (1+2^-6, tie, even) -> 0x40, inexact=1
  - 0x3F860000 (1+3/64) -> 0x42
  - 0x42400000 (48.0, tie) -> 0x7E
  - 0x42600000 (56.0) -> 0x7F, sat=0
- Clamp and special:
  - 0x42C80000 (100.0) -> 0x7F, sat=1
  - 0x3B800000 (2^-8) -> 0x01, sat=1
  - 0x00000001 (denorm) -> 0x01, sat=1
  - 0xC2C80000 (-100.0) -> 0x81
  - 0x7FC00000 (NaN) -> 0x80
  - 0x7F800000 (Inf) -> 0x80
- Backpressure: stream 6 words with out_ready low for cycles 3-6 -> in_ready drops after 2 buffered entries. Outputs hold stable while stalled; all 6 results arrive in order with none lost or duplicated.
- Async reset asserted mid-stream with 2 words in flight -> out_valid drops immediately without waiting for a clk edge. After release, no stale result appears.
